// File: rtl/inst_queue.sv
// inst_queue: dual-push, dual-pop circular instruction queue between fetch and decode
package inst_queue_pkg;
  typedef logic [5:0] exception_t;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic [1:0]        in_valid,
  output logic              in_ready,
  input  logic [31:0]       in0_pc,
  input  logic [31:0]       in1_pc,
  input  logic [31:0]       in0_inst,
  input  logic [31:0]       in1_inst,
  input  logic              in0_pred_taken,
  input  logic              in1_pred_taken,
  input  logic [31:0]       in0_pred_target,
  input  logic [31:0]       in1_pred_target,
  input  logic              in0_have_exception,
  input  logic              in1_have_exception,
  input  exception_t        in0_exception_type,
  input  exception_t        in1_exception_type,
  input  logic [1:0]        consume,
  output logic              a_valid,
  output logic              b_valid,
  output logic [31:0]       a_pc,
  output logic [31:0]       a_inst,
  output logic              a_pred_taken,
  output logic [31:0]       a_pred_target,
  output logic              a_have_exception,
  output exception_t        a_exception_type,
  output logic [31:0]       b_pc,
  output logic [31:0]       b_inst,
  output logic              b_pred_taken,
  output logic [31:0]       b_pred_target,
  output logic              b_have_exception,
  output exception_t        b_exception_type,
  output logic [CW-1:0]     iq_count
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        have_exception;
    exception_t  exception_type;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          e0, e1, ea, eb;
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;
  logic [1:0]      push_n, pop_n, cons;

  assign e0 = '{in0_pc, in0_inst, in0_pred_taken, in0_pred_target, in0_have_exception, in0_exception_type};
  assign e1 = '{in1_pc, in1_inst, in1_pred_taken, in1_pred_target, in1_have_exception, in1_exception_type};

  assign in_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign push_n   = in_ready ? (in_valid == 2'b11 ? 2'd2 : in_valid[0] ? 2'd1 : 2'd0) : 2'd0;
  assign cons     = consume == 2'd3 ? 2'd2 : consume;
  assign pop_n    = CW'(cons) > count ? count[1:0] : cons;

  assign ea = mem[head];
  assign eb = mem[head + AW'(1)];

  assign a_valid          = count >= CW'(1);
  assign b_valid          = count >= CW'(2);
  assign a_pc             = ea.pc;
  assign a_inst           = ea.inst;
  assign a_pred_taken     = ea.pred_taken;
  assign a_pred_target    = ea.pred_target;
  assign a_have_exception = ea.have_exception;
  assign a_exception_type = ea.exception_type;
  assign b_pc             = eb.pc;
  assign b_inst           = eb.inst;
  assign b_pred_taken     = eb.pred_taken;
  assign b_pred_target    = eb.pred_target;
  assign b_have_exception = eb.have_exception;
  assign b_exception_type = eb.exception_type;
  assign iq_count         = count;

  // pointers and occupancy; flush overrides any push/pop in the same cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // entry storage; a flushed cycle writes nothing
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!flush) begin
      if (push_n != 2'd0) mem[tail] <= e0;
      if (push_n == 2'd2) mem[tail + AW'(1)] <= e1;
    end
  end

  // decode must never ask for more entries than are present
  always_ff @(posedge clk) begin
    if (resetn && !flush) assert (CW'(consume) <= count);
  end
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed plan plus randomized traffic against a queue-based reference model
module tb_inst_queue;
  import inst_queue_pkg::*;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pt;
    logic [31:0] tgt;
    logic        he;
    exception_t  et;
  } ent_t;

  logic clk = 0, resetn = 0, flush = 0;
  logic [1:0] in_valid = 0, consume = 0;
  logic in_ready;
  logic [31:0] in0_pc = 0, in1_pc = 0, in0_inst = 0, in1_inst = 0, in0_pred_target = 0, in1_pred_target = 0;
  logic in0_pred_taken = 0, in1_pred_taken = 0, in0_have_exception = 0, in1_have_exception = 0;
  exception_t in0_exception_type = 0, in1_exception_type = 0;
  logic a_valid, b_valid, a_pred_taken, b_pred_taken, a_have_exception, b_have_exception;
  logic [31:0] a_pc, a_inst, a_pred_target, b_pc, b_inst, b_pred_target;
  exception_t a_exception_type, b_exception_type;
  logic [CW-1:0] iq_count;

  int compared = 0, mismatched = 0;
  ent_t q[$];
  logic [31:0] saved_pc;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in0_pc(in0_pc), .in1_pc(in1_pc), .in0_inst(in0_inst), .in1_inst(in1_inst),
    .in0_pred_taken(in0_pred_taken), .in1_pred_taken(in1_pred_taken),
    .in0_pred_target(in0_pred_target), .in1_pred_target(in1_pred_target),
    .in0_have_exception(in0_have_exception), .in1_have_exception(in1_have_exception),
    .in0_exception_type(in0_exception_type), .in1_exception_type(in1_exception_type),
    .consume(consume), .a_valid(a_valid), .b_valid(b_valid),
    .a_pc(a_pc), .a_inst(a_inst), .a_pred_taken(a_pred_taken), .a_pred_target(a_pred_target),
    .a_have_exception(a_have_exception), .a_exception_type(a_exception_type),
    .b_pc(b_pc), .b_inst(b_inst), .b_pred_taken(b_pred_taken), .b_pred_target(b_pred_target),
    .b_have_exception(b_have_exception), .b_exception_type(b_exception_type),
    .iq_count(iq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = q.size();
    chk("iq_count", 64'(iq_count), 64'(n));
    chk("in_ready", 64'(in_ready), 64'(DEPTH - n >= 2));
    chk("a_valid", 64'(a_valid), 64'(n >= 1));
    chk("b_valid", 64'(b_valid), 64'(n >= 2));
    if (n >= 1) begin
      chk("a_pc", 64'(a_pc), 64'(q[0].pc));
      chk("a_inst", 64'(a_inst), 64'(q[0].inst));
      chk("a_pred_taken", 64'(a_pred_taken), 64'(q[0].pt));
      chk("a_pred_target", 64'(a_pred_target), 64'(q[0].tgt));
      chk("a_have_exception", 64'(a_have_exception), 64'(q[0].he));
      chk("a_exception_type", 64'(a_exception_type), 64'(q[0].et));
    end
    if (n >= 2) begin
      chk("b_pc", 64'(b_pc), 64'(q[1].pc));
      chk("b_inst", 64'(b_inst), 64'(q[1].inst));
      chk("b_pred_taken", 64'(b_pred_taken), 64'(q[1].pt));
      chk("b_pred_target", 64'(b_pred_target), 64'(q[1].tgt));
      chk("b_have_exception", 64'(b_have_exception), 64'(q[1].he));
      chk("b_exception_type", 64'(b_exception_type), 64'(q[1].et));
    end
  endtask

  // one clock: drive inputs, let the edge happen, advance the model, then check
  task automatic cyc(input logic [1:0] iv, input logic [1:0] cn, input logic fl,
                     input logic [31:0] p0, input logic [31:0] p1);
    int pops;
    in_valid = iv; consume = cn; flush = fl;
    in0_pc = p0; in1_pc = p1;
    in0_inst = $urandom; in1_inst = $urandom;
    in0_pred_taken = 1'($urandom); in1_pred_taken = 1'($urandom);
    in0_pred_target = $urandom; in1_pred_target = $urandom;
    in0_have_exception = 1'($urandom); in1_have_exception = 1'($urandom);
    in0_exception_type = exception_t'($urandom); in1_exception_type = exception_t'($urandom);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      bit can_take = (DEPTH - q.size()) >= 2;
      pops = (cn == 3) ? 2 : cn;
      if (pops > q.size()) pops = q.size();
      repeat (pops) void'(q.pop_front());
      if (can_take && iv[0])
        q.push_back('{in0_pc, in0_inst, in0_pred_taken, in0_pred_target, in0_have_exception, in0_exception_type});
      if (can_take && iv == 2'b11)
        q.push_back('{in1_pc, in1_inst, in1_pred_taken, in1_pred_target, in1_have_exception, in1_exception_type});
    end
    #1;
    check_all();
  endtask

  initial begin
    // reset then idle
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("rst_a_pc", 64'(a_pc), 64'h0);
    chk("rst_b_inst", 64'(b_inst), 64'h0);
    @(negedge clk);
    resetn = 1;
    cyc(2'b00, 0, 0, 0, 0);
    // order and dual pop
    cyc(2'b11, 0, 0, 32'h1c000000, 32'h1c000004);
    chk("ord_a0", 64'(a_pc), 64'h1c000000);
    cyc(2'b11, 0, 0, 32'h1c000008, 32'h1c00000c);
    chk("ord_cnt4", 64'(iq_count), 64'd4);
    cyc(2'b00, 2, 0, 0, 0);
    chk("ord_a1", 64'(a_pc), 64'h1c000008);
    chk("ord_b1", 64'(b_pc), 64'h1c00000c);
    // fill and backpressure
    cyc(2'b11, 0, 0, $urandom, $urandom);
    cyc(2'b11, 0, 0, $urandom, $urandom);
    cyc(2'b11, 0, 0, $urandom, $urandom);
    chk("full_cnt", 64'(iq_count), 64'd8);
    chk("full_rdy", 64'(in_ready), 64'd0);
    cyc(2'b11, 0, 0, $urandom, $urandom);
    chk("full_nopush", 64'(iq_count), 64'd8);
    cyc(2'b00, 1, 0, 0, 0);
    chk("cnt7_rdy", 64'(in_ready), 64'd0);
    cyc(2'b00, 1, 0, 0, 0);
    chk("cnt6_rdy", 64'(in_ready), 64'd1);
    cyc(2'b00, 0, 1, 0, 0);
    // wrap-around
    repeat (7) begin
      cyc(2'b01, 0, 0, $urandom, 0);
      cyc(2'b00, 1, 0, 0, 0);
    end
    cyc(2'b11, 0, 0, 32'h100, 32'h104);
    chk("wrap_a", 64'(a_pc), 64'h100);
    chk("wrap_b", 64'(b_pc), 64'h104);
    chk("wrap_cnt", 64'(iq_count), 64'd2);
    // simultaneous push/pop
    cyc(2'b01, 0, 0, 32'h300, 0);
    saved_pc = 32'h300;
    cyc(2'b11, 2, 0, 32'h304, 32'h308);
    chk("sim_cnt", 64'(iq_count), 64'd3);
    chk("sim_a", 64'(a_pc), 64'(saved_pc));
    // flush priority
    cyc(2'b11, 0, 0, $urandom, $urandom);
    chk("pre_flush_cnt", 64'(iq_count), 64'd5);
    cyc(2'b11, 1, 1, $urandom, $urandom);
    chk("flush_cnt", 64'(iq_count), 64'd0);
    chk("flush_rdy", 64'(in_ready), 64'd1);
    cyc(2'b01, 0, 0, 32'h200, 0);
    chk("post_flush_a", 64'(a_pc), 64'h200);
    chk("post_flush_b", 64'(b_valid), 64'd0);
    // illegal slot1-only group is ignored
    cyc(2'b10, 0, 0, $urandom, $urandom);
    chk("iv10_cnt", 64'(iq_count), 64'd1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r = $urandom_range(0, 99);
      logic [1:0] iv = r < 30 ? 2'b11 : r < 60 ? 2'b01 : r < 63 ? 2'b10 : 2'b00;
      int mx = q.size() < 2 ? q.size() : 2;
      cyc(iv, 2'($urandom_range(0, mx)), $urandom_range(0, 99) < 3, $urandom, $urandom);
    end
    // asynchronous reset mid-operation
    cyc(2'b11, 0, 0, $urandom, $urandom);
    resetn = 0;
    #1;
    q.delete();
    check_all();
    chk("async_a_pc", 64'(a_pc), 64'h0);
    @(negedge clk);
    resetn = 1;
    cyc(2'b01, 0, 0, 32'h400, 0);
    chk("after_rst_a", 64'(a_pc), 64'h400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
